// File: rtl/conv2_rm_sram_ctrl.sv
// Access controller for the conv2 16x288 single-port SRAM: write/read arbitration, 2-cycle read return, zero-fill sequencer.
// Optional feature macro: SRAM_CTRL_BOUNDS_CHECK_EN (out-of-range requests are accepted but blocked from the macro).
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | arbitrate write/read requesters onto the macro
// ST_INIT | walk 0..DEPTH-1 writing INIT_VALUE, no grants
module conv2_rm_sram_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 288,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 16'h0000
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_rvalid,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  addr_err,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic {ST_IDLE, ST_INIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic                  last_wr_q;
    logic [1:0]            rd_pend_q;
    logic [1:0]            rd_oob_q;
    logic                  wr_acc, rd_acc;
    logic                  wr_oob, rd_oob;
    logic                  init_last;

    assign init_last = (init_cnt_q == ADDR_WIDTH'(DEPTH - 1));
    assign init_busy = (state_q == ST_INIT);
    assign wr_acc    = wr_valid && wr_ready;
    assign rd_acc    = rd_valid && rd_ready;

`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    assign wr_oob = (32'(wr_addr) >= 32'(DEPTH));
    assign rd_oob = (32'(rd_addr) >= 32'(DEPTH));
`else
    assign wr_oob = 1'b0;
    assign rd_oob = 1'b0;
`endif

    // Round-robin on conflict: the requester not granted last time wins.
    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    state_d = ST_INIT;
                end else if (wr_valid && (!rd_valid || !last_wr_q)) begin
                    wr_ready = 1'b1;
                end else if (rd_valid) begin
                    rd_ready = 1'b1;
                end
            end
            ST_INIT: begin
                if (init_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
            last_wr_q  <= 1'b0;
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            rd_pend_q  <= '0;
            rd_oob_q   <= '0;
            rd_rvalid  <= 1'b0;
            rd_rdata   <= '0;
            init_done  <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sram_csb0 <= 1'b1;
            sram_web0 <= 1'b1;
            init_done <= 1'b0;
            addr_err  <= 1'b0;

            if (state_q == ST_INIT) begin
                sram_csb0  <= 1'b0;
                sram_web0  <= 1'b0;
                sram_addr0 <= init_cnt_q;
                sram_din0  <= INIT_VALUE;
                if (init_last) begin
                    init_cnt_q <= '0;
                    init_done  <= 1'b1;
                end else begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                end
            end

            if (wr_acc) begin
                last_wr_q  <= 1'b1;
                sram_addr0 <= wr_addr;
                sram_din0  <= wr_data;
                addr_err   <= wr_oob;
                if (!wr_oob) begin
                    sram_csb0 <= 1'b0;
                    sram_web0 <= 1'b0;
                end
            end

            if (rd_acc) begin
                last_wr_q  <= 1'b0;
                sram_addr0 <= rd_addr;
                addr_err   <= rd_oob;
                if (!rd_oob) sram_csb0 <= 1'b0;
            end

            // Macro data is valid one cycle after it samples the command.
            rd_pend_q <= {rd_pend_q[0], rd_acc};
            rd_oob_q  <= {rd_oob_q[0], rd_acc && rd_oob};
            rd_rvalid <= rd_pend_q[1];
            if (rd_pend_q[1]) rd_rdata <= rd_oob_q[1] ? '0 : sram_dout0;
        end
    end

endmodule

// File: tb/tb_conv2_rm_sram_ctrl.sv
// Directed self-checking bench for conv2_rm_sram_ctrl with a behavioural single-port SRAM model.
module tb_conv2_rm_sram_ctrl;

    logic        clk0 = 1'b0;
    logic        rst0 = 1'b1;
    logic        wr_valid = 1'b0, wr_ready;
    logic [8:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_valid = 1'b0, rd_ready;
    logic [8:0]  rd_addr = '0;
    logic        rd_rvalid;
    logic [15:0] rd_rdata;
    logic        init_start = 1'b0, init_busy, init_done, addr_err;
    logic        sram_csb0, sram_web0;
    logic [8:0]  sram_addr0;
    logic [15:0] sram_din0;
    logic [15:0] sram_dout0 = '0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [512];

    always #5 clk0 = ~clk0;

    conv2_rm_sram_ctrl dut (
        .clk0(clk0), .rst0(rst0),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done), .addr_err(addr_err),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h5A00 ^ 16'(i);
    end

    always @(posedge clk0) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else            sram_dout0 <= mem[sram_addr0];
        end
    end

    task automatic apply_reset();
        @(negedge clk0);
        rst0 = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; init_start = 1'b0;
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        rst0 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk0);
        rst0 = 1'b1;
        repeat (2) @(posedge clk0);
        #1;
        checks++;
        if ({sram_csb0, sram_web0} !== 2'b11) begin
            errors++; $display("FAIL reset_csb_web: got %b expected 11", {sram_csb0, sram_web0});
        end
        checks++;
        if ({rd_rvalid, init_busy, init_done, addr_err, wr_ready, rd_ready} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {rd_rvalid, init_busy, init_done, addr_err, wr_ready, rd_ready});
        end
        checks++;
        if ({sram_addr0, sram_din0, rd_rdata} !== 41'b0) begin
            errors++; $display("FAIL reset_data: addr %h din %h rdata %h expected zeros",
                               sram_addr0, sram_din0, rd_rdata);
        end
        @(negedge clk0);
        rst0 = 1'b0;
    endtask

    task automatic test_raw();
        @(negedge clk0);
        wr_valid = 1'b1; wr_addr = 9'd5; wr_data = 16'hA5A5;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL raw_wr_ready: got %b expected 1", wr_ready); end
        @(posedge clk0); #1;
        checks++;
        if ({sram_csb0, sram_web0, sram_addr0, sram_din0} !== {2'b00, 9'd5, 16'hA5A5}) begin
            errors++; $display("FAIL raw_wr_cmd: csb %b web %b addr %0d din %h expected 0 0 5 a5a5",
                               sram_csb0, sram_web0, sram_addr0, sram_din0);
        end
        @(negedge clk0);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'd5;
        #1;
        checks++;
        if (rd_ready !== 1'b1) begin errors++; $display("FAIL raw_rd_ready: got %b expected 1", rd_ready); end
        @(posedge clk0); #1;
        checks++;
        if ({sram_csb0, sram_web0, sram_addr0} !== {2'b01, 9'd5}) begin
            errors++; $display("FAIL raw_rd_cmd: csb %b web %b addr %0d expected 0 1 5",
                               sram_csb0, sram_web0, sram_addr0);
        end
        @(negedge clk0);
        rd_valid = 1'b0;
        @(posedge clk0); #1;
        checks++;
        if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL raw_lat1: rvalid %b expected 0", rd_rvalid); end
        @(posedge clk0); #1;
        checks++;
        if ({rd_rvalid, rd_rdata} !== {1'b1, 16'hA5A5}) begin
            errors++; $display("FAIL raw_lat2: rvalid %b rdata %h expected 1 a5a5", rd_rvalid, rd_rdata);
        end
        @(posedge clk0); #1;
        checks++;
        if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL raw_pulse: rvalid %b expected 0", rd_rvalid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk0);
            wr_valid = (c < 8); rd_valid = (c < 8);
            wr_addr = 9'(20 + c); wr_data = 16'(16'h1000 + c); rd_addr = 9'(19 + c);
            #1;
            if (c < 8) begin
                checks++;
                if ({wr_ready, rd_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL b2b_grant c=%0d: wr_ready %b rd_ready %b expected %s",
                                       c, wr_ready, rd_ready, (c % 2 == 0) ? "W" : "R");
                end
            end
            @(posedge clk0); #1;
            if (c >= 3 && c - 2 < 8 && (c - 2) % 2 == 1) begin
                checks++;
                if ({rd_rvalid, rd_rdata} !== {1'b1, 16'(16'h1000 + c - 3)}) begin
                    errors++; $display("FAIL b2b_resp c=%0d: rvalid %b rdata %h expected 1 %h",
                                       c, rd_rvalid, rd_rdata, 16'(16'h1000 + c - 3));
                end
            end else begin
                checks++;
                if (rd_rvalid !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle c=%0d: rvalid %b expected 0", c, rd_rvalid);
                end
            end
        end
    endtask

    task automatic test_init();
        int busy_cnt = 0;
        int done_cnt = 0;
        int ready_bad = 0;
        logic [8:0] addrs [3] = '{9'd0, 9'd143, 9'd287};
        @(negedge clk0);
        init_start = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        #1;
        checks++;
        if ({wr_ready, rd_ready} !== 2'b00) begin
            errors++; $display("FAIL init_priority: wr_ready %b rd_ready %b expected 00", wr_ready, rd_ready);
        end
        @(posedge clk0);
        @(negedge clk0);
        init_start = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (init_done) done_cnt++;
            if (!init_busy && busy_cnt > 0) break;
            if (init_busy) begin
                busy_cnt++;
                if (wr_ready || rd_ready) ready_bad++;
            end
            init_start = (busy_cnt == 50);
            @(negedge clk0);
        end
        wr_valid = 1'b0; rd_valid = 1'b0; init_start = 1'b0;
        checks++;
        if (busy_cnt !== 288) begin errors++; $display("FAIL init_busy_len: got %0d expected 288", busy_cnt); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL init_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (ready_bad !== 0) begin errors++; $display("FAIL init_ready: %0d cycles with ready expected 0", ready_bad); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk0);
            rd_valid = (c < 3);
            rd_addr = (c < 3) ? addrs[c] : 9'd0;
            @(posedge clk0); #1;
            checks++;
            if (c >= 2) begin
                if ({rd_rvalid, rd_rdata} !== {1'b1, 16'h0000}) begin
                    errors++; $display("FAIL init_read addr=%0d: rvalid %b rdata %h expected 1 0000",
                                       addrs[c - 2], rd_rvalid, rd_rdata);
                end
            end else if (rd_rvalid !== 1'b0) begin
                errors++; $display("FAIL init_read_early c=%0d: rvalid %b expected 0", c, rd_rvalid);
            end
        end
        @(negedge clk0);
        rd_valid = 1'b0;
    endtask

    task automatic test_init_reset();
        int done_cnt = 0;
        @(negedge clk0);
        init_start = 1'b1;
        @(posedge clk0);
        @(negedge clk0);
        init_start = 1'b0;
        repeat (100) @(negedge clk0);
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL initrst_busy_pre: got %b expected 1", init_busy); end
        rst0 = 1'b1;
        @(posedge clk0); #1;
        checks++;
        if ({init_busy, init_done, sram_csb0} !== 3'b001) begin
            errors++; $display("FAIL initrst_after: busy %b done %b csb %b expected 0 0 1",
                               init_busy, init_done, sram_csb0);
        end
        @(negedge clk0);
        rst0 = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk0);
            if (init_done || init_busy || !sram_csb0) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL initrst_quiet: %0d active cycles expected 0", done_cnt); end
    endtask

    task automatic test_bounds();
        @(negedge clk0);
        rd_valid = 1'b1; rd_addr = 9'd300;
        #1;
        checks++;
        if (rd_ready !== 1'b1) begin errors++; $display("FAIL oob_ready: got %b expected 1", rd_ready); end
        @(posedge clk0); #1;
        checks++;
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
        if ({addr_err, sram_csb0} !== 2'b11) begin
            errors++; $display("FAIL oob_cmd: addr_err %b csb %b expected 1 1", addr_err, sram_csb0);
        end
`else
        if ({addr_err, sram_csb0, sram_addr0} !== {2'b00, 9'd300}) begin
            errors++; $display("FAIL oob_cmd: addr_err %b csb %b addr %0d expected 0 0 300",
                               addr_err, sram_csb0, sram_addr0);
        end
`endif
        @(negedge clk0);
        rd_valid = 1'b0;
        @(posedge clk0); #1;
        checks++;
        if ({addr_err, rd_rvalid} !== 2'b00) begin
            errors++; $display("FAIL oob_lat1: addr_err %b rvalid %b expected 0 0", addr_err, rd_rvalid);
        end
        @(posedge clk0); #1;
        checks++;
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
        if ({rd_rvalid, rd_rdata} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL oob_resp: rvalid %b rdata %h expected 1 0000", rd_rvalid, rd_rdata);
        end
`else
        if ({rd_rvalid, rd_rdata} !== {1'b1, 16'h5A00 ^ 16'd300}) begin
            errors++; $display("FAIL oob_resp: rvalid %b rdata %h expected 1 %h",
                               rd_rvalid, rd_rdata, 16'h5A00 ^ 16'd300);
        end
`endif
    endtask

    task automatic test_reset_flush();
        int seen = 0;
        @(negedge clk0);
        rd_valid = 1'b1; rd_addr = 9'd5;
        @(posedge clk0);
        @(negedge clk0);
        rd_addr = 9'd6;
        @(posedge clk0);
        @(negedge clk0);
        rd_valid = 1'b0; rst0 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk0); #1;
            if (rd_rvalid) seen++;
            if (n == 1) rst0 = 1'b0;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_rvalid: %0d pulses expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_back_to_back();
        test_init();
        test_init_reset();
        test_bounds();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
